// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/stall control interface between pipeline datapath and pipe_ctrl
interface pipe_ctrl_if;
  // ID-stage source registers
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  // EX-stage destination
  logic [4:0]  ex_writereg;
  logic        ex_regwrite;
  logic        ex_memtoreg;
  // divider handshake
  logic        div_start;
  logic        div_done;
  logic        div_cancel;
  // memory and exception events
  logic        dmem_busy;
  logic        except_valid;
  // stage holds
  logic        stall_f;
  logic        stall_d;
  logic        stall_e;
  logic        stall_m;
  logic        stall_w;
  // stage clears
  logic        flush_d;
  logic        flush_e;
  logic        flush_m;
  logic        flush_w;
  // fetch redirect and stall statistics
  logic        redirect;
  logic [31:0] stall_cnt;
  // stall counter preset
  logic        cnt_wr_en;
  logic [31:0] cnt_wr_data;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt,
    output ex_writereg, ex_regwrite, ex_memtoreg,
    output div_start, div_done, dmem_busy, except_valid,
    output cnt_wr_en, cnt_wr_data,
    input  div_cancel,
    input  stall_f, stall_d, stall_e, stall_m, stall_w,
    input  flush_d, flush_e, flush_m, flush_w,
    input  redirect, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt,
    input  ex_writereg, ex_regwrite, ex_memtoreg,
    input  div_start, div_done, dmem_busy, except_valid,
    input  cnt_wr_en, cnt_wr_data,
    output div_cancel,
    output stall_f, stall_d, stall_e, stall_m, stall_w,
    output flush_d, flush_e, flush_m, flush_w,
    output redirect, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - five-stage pipeline stall/flush/redirect controller
module pipe_ctrl (
  input  logic   clk,
  input  logic   resetn,
  pipe_ctrl_if.slave pc
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV_BUSY  = 2'd1,
    EXC_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        load_use;
  logic        rs_hit;
  logic        rt_hit;
  logic [31:0] stall_cnt_q;

  logic s_f, s_d, s_e, s_m, s_w;
  logic f_d, f_e, f_m, f_w;
  logic redir, dcancel;

  // A load in EX whose destination a live ID source reads; r0 never hazards
  assign rs_hit   = pc.id_use_rs && (pc.id_rs == pc.ex_writereg);
  assign rt_hit   = pc.id_use_rt && (pc.id_rt == pc.ex_writereg);
  assign load_use = pc.ex_memtoreg && pc.ex_regwrite &&
                    (pc.ex_writereg != 5'd0) && (rs_hit || rt_hit);

  // State register; reset abandons any divide or drain in progress
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: exception first, memory stall freezes the sequence,
  // then the divide handshake
  always_comb begin
    state_d = state_q;
    if (pc.except_valid) begin
      state_d = EXC_DRAIN;
    end else if (pc.dmem_busy) begin
      // a div_done arriving now is not consumed; the divider keeps it
      state_d = state_q;
    end else begin
      case (state_q)
        IDLE:      state_d = pc.div_start ? DIV_BUSY : IDLE;
        DIV_BUSY:  state_d = pc.div_done ? IDLE : DIV_BUSY;
        EXC_DRAIN: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output decode: only the highest-priority active event drives the pipeline
  always_comb begin
    s_f     = 1'b0;
    s_d     = 1'b0;
    s_e     = 1'b0;
    s_m     = 1'b0;
    s_w     = 1'b0;
    f_d     = 1'b0;
    f_e     = 1'b0;
    f_m     = 1'b0;
    f_w     = 1'b0;
    redir   = 1'b0;
    dcancel = 1'b0;
    if (!resetn) begin
      // everything stays quiet while held in reset
      s_f = 1'b0;
    end else if (pc.except_valid) begin
      f_d     = 1'b1;
      f_e     = 1'b1;
      f_m     = 1'b1;
      f_w     = 1'b1;
      redir   = 1'b1;
      dcancel = (state_q == DIV_BUSY);
    end else if (pc.dmem_busy) begin
      // hold F..M on the MEM access, send a bubble into WB
      s_f = 1'b1;
      s_d = 1'b1;
      s_e = 1'b1;
      s_m = 1'b1;
      f_w = 1'b1;
    end else begin
      case (state_q)
        EXC_DRAIN: begin
          // the fetch issued before the redirect is still in flight
          f_d = 1'b1;
        end
        DIV_BUSY: begin
          if (!pc.div_done) begin
            s_f = 1'b1;
            s_d = 1'b1;
            s_e = 1'b1;
            f_m = 1'b1;
          end
        end
        default: begin
          if (pc.div_start) begin
            s_f = 1'b1;
            s_d = 1'b1;
            s_e = 1'b1;
            f_m = 1'b1;
          end else if (load_use) begin
            s_f = 1'b1;
            s_d = 1'b1;
            f_e = 1'b1;
          end
        end
      endcase
    end
  end

  // Count fetch-stall cycles; preset lets software seed the counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt_q <= 32'd0;
    end else if (pc.cnt_wr_en) begin
      stall_cnt_q <= pc.cnt_wr_data;
    end else if (s_f) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign pc.stall_f    = s_f;
  assign pc.stall_d    = s_d;
  assign pc.stall_e    = s_e;
  assign pc.stall_m    = s_m;
  assign pc.stall_w    = s_w;
  assign pc.flush_d    = f_d;
  assign pc.flush_e    = f_e;
  assign pc.flush_m    = f_m;
  assign pc.flush_w    = f_w;
  assign pc.redirect   = redir;
  assign pc.div_cancel = dcancel;
  assign pc.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - randomized and directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   failures = 0;

  // reference model: 0 running, 1 waiting on divider, 2 draining after exception
  int          m_mode;
  logic [31:0] m_cnt;
  logic [10:0] o;

  localparam logic [10:0] P_NONE = 11'b00000_0000_00;
  localparam logic [10:0] P_LU   = 11'b11000_0100_00;
  localparam logic [10:0] P_DIV  = 11'b11100_0010_00;
  localparam logic [10:0] P_MEM  = 11'b11110_0001_00;
  localparam logic [10:0] P_DRN  = 11'b00000_1000_00;

  always #5 clk = ~clk;

  pipe_ctrl_if pif ();

  pipe_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .pc     (pif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] observed();
    return {pif.stall_f, pif.stall_d, pif.stall_e, pif.stall_m, pif.stall_w,
            pif.flush_d, pif.flush_e, pif.flush_m, pif.flush_w,
            pif.redirect, pif.div_cancel};
  endfunction

  function automatic logic [10:0] model_out();
    logic hz;
    hz = pif.ex_memtoreg && pif.ex_regwrite && pif.ex_writereg != 0 &&
         ((pif.id_use_rs && pif.id_rs == pif.ex_writereg) ||
          (pif.id_use_rt && pif.id_rt == pif.ex_writereg));
    if (!resetn)          return P_NONE;
    if (pif.except_valid) return {7'b0000011, 4'b0};
    if (pif.dmem_busy)    return P_MEM;
    if (m_mode == 2)      return P_DRN;
    if (m_mode == 1)      return pif.div_done ? P_NONE : P_DIV;
    if (pif.div_start)    return P_DIV;
    if (hz)               return P_LU;
    return P_NONE;
  endfunction

  task automatic quiet();
    pif.id_rs = 0; pif.id_rt = 0; pif.id_use_rs = 0; pif.id_use_rt = 0;
    pif.ex_writereg = 0; pif.ex_regwrite = 0; pif.ex_memtoreg = 0;
    pif.div_start = 0; pif.div_done = 0; pif.dmem_busy = 0; pif.except_valid = 0;
    pif.cnt_wr_en = 0; pif.cnt_wr_data = 0;
  endtask

  task automatic load_use(input logic [4:0] wr);
    pif.ex_memtoreg = 1; pif.ex_regwrite = 1; pif.ex_writereg = wr;
    pif.id_rs = 8; pif.id_use_rs = 1;
  endtask

  // one clock: compare against the model mid-cycle, then advance the model
  task automatic step(output logic [10:0] obs);
    logic [10:0] exp;
    @(negedge clk);
    exp = model_out();
    // exception outputs carry div_cancel only when the model is waiting on the divider
    if (resetn && pif.except_valid)
      exp = {5'b0, 4'b1111, 1'b1, (m_mode == 1)};
    obs = observed();
    check("ctl", {21'd0, obs}, {21'd0, exp});
    check("cnt", pif.stall_cnt, m_cnt);
    @(posedge clk);
    if (!resetn) begin
      m_mode = 0;
      m_cnt  = 0;
    end else begin
      if (pif.cnt_wr_en) m_cnt = pif.cnt_wr_data;
      else if (exp[10]) m_cnt = m_cnt + 1;
      if (pif.except_valid)   m_mode = 2;
      else if (!pif.dmem_busy) begin
        if (m_mode == 0)      m_mode = pif.div_start ? 1 : 0;
        else if (m_mode == 1) m_mode = pif.div_done ? 0 : 1;
        else                  m_mode = 0;
      end
    end
    #1;
  endtask

  initial begin
    quiet();
    resetn = 0;
    @(posedge clk); #1;
    m_mode = 0; m_cnt = 0;
    step(o);
    check("rst_out", {21'd0, o}, {21'd0, P_NONE});
    check("rst_cnt", pif.stall_cnt, 32'd0);
    resetn = 1;

    // load-use hazard: one-cycle bubble
    load_use(8);
    step(o);
    check("lu_out", {21'd0, o}, {21'd0, P_LU});
    check("lu_cnt", pif.stall_cnt, 32'd1);
    quiet();
    step(o);
    check("lu_once", {21'd0, o}, {21'd0, P_NONE});

    // r0 destination never hazards
    load_use(0);
    step(o);
    check("r0_out", {21'd0, o}, {21'd0, P_NONE});
    check("r0_cnt", pif.stall_cnt, 32'd1);

    // divide taking six cycles
    quiet(); resetn = 0; step(o); resetn = 1;
    pif.div_start = 1;
    for (int c = 0; c < 5; c++) begin
      step(o);
      check("div_busy", {21'd0, o}, {21'd0, P_DIV});
    end
    pif.div_start = 0; pif.div_done = 1;
    step(o);
    check("div_done", {21'd0, o}, {21'd0, P_NONE});
    pif.div_done = 0;
    step(o);
    check("div_idle", {21'd0, o}, {21'd0, P_NONE});
    check("div_cnt", pif.stall_cnt, 32'd5);

    // exception during divide
    pif.div_start = 1;
    step(o);
    pif.div_start = 0;
    step(o);
    step(o);
    pif.except_valid = 1;
    step(o);
    check("exc_out", {21'd0, o}, {21'd0, 11'b00000_1111_11});
    pif.except_valid = 0;
    step(o);
    check("exc_drain", {21'd0, o}, {21'd0, P_DRN});
    step(o);
    check("exc_idle", {21'd0, o}, {21'd0, P_NONE});

    // memory stall outranks load-use, which follows once memory is ready
    load_use(8);
    pif.dmem_busy = 1;
    for (int c = 0; c < 3; c++) begin
      step(o);
      check("mem_stall", {21'd0, o}, {21'd0, P_MEM});
    end
    pif.dmem_busy = 0;
    step(o);
    check("mem_lu", {21'd0, o}, {21'd0, P_LU});
    quiet();
    step(o);
    check("mem_after", {21'd0, o}, {21'd0, P_NONE});

    // counter wrap from a preset value
    pif.cnt_wr_en = 1; pif.cnt_wr_data = 32'hFFFF_FFFE;
    step(o);
    pif.cnt_wr_en = 0;
    check("pre_cnt", pif.stall_cnt, 32'hFFFF_FFFE);
    load_use(8);
    step(o);
    step(o);
    check("wrap_cnt", pif.stall_cnt, 32'h0000_0000);
    quiet();

    // reset in the middle of a divide
    pif.div_start = 1;
    step(o);
    step(o);
    resetn = 0;
    step(o);
    check("rdiv_out", {21'd0, o}, {21'd0, P_NONE});
    resetn = 1;
    pif.div_start = 0;
    step(o);
    check("rdiv_idle", {21'd0, o}, {21'd0, P_NONE});
    check("rdiv_cnt", pif.stall_cnt, 32'd0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      resetn           = ($urandom_range(0, 99) != 0);
      pif.except_valid = ($urandom_range(0, 19) == 0);
      pif.dmem_busy    = ($urandom_range(0, 5) == 0);
      pif.div_start    = ($urandom_range(0, 3) == 0);
      pif.div_done     = ($urandom_range(0, 3) == 0);
      pif.ex_memtoreg  = 1'($urandom_range(0, 1));
      pif.ex_regwrite  = ($urandom_range(0, 3) != 0);
      pif.ex_writereg  = 5'($urandom_range(0, 3));
      pif.id_rs        = 5'($urandom_range(0, 3));
      pif.id_rt        = 5'($urandom_range(0, 3));
      pif.id_use_rs    = 1'($urandom_range(0, 1));
      pif.id_use_rt    = 1'($urandom_range(0, 1));
      pif.cnt_wr_en    = ($urandom_range(0, 199) == 0);
      pif.cnt_wr_data  = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have ports: clk in 1, pipeline clock; resetn in 1, synchronous active-low reset; clock clk.
REQ-002 The block SHALL have ports id_rs, id_rt in 5 each, ID source registers; id_use_rs, id_use_rt in 1 each, source actually read.
REQ-003 The block SHALL have ports ex_writereg in 5, EX destination; ex_regwrite in 1; ex_memtoreg in 1, EX is a load.
REQ-004 The block SHALL have ports div_start in 1, EX holds a div/divu; div_done in 1, divider result valid this cycle; div_cancel out 1, abort divider.
REQ-005 The block SHALL have port dmem_busy in 1, data SRAM not ready for the MEM access.
REQ-006 The block SHALL have port except_valid in 1, exception/eret committed in MEM.
REQ-007 The block SHALL have outputs stall_f, stall_d, stall_e, stall_m, stall_w out 1 each, stage register hold.
REQ-008 The block SHALL have outputs flush_d, flush_e, flush_m, flush_w out 1 each, stage register clear (flush overrides stall in the stage).
REQ-009 The block SHALL have outputs redirect out 1, fetch PC load from exception vector; stall_cnt out 32, cycles with stall_f high.

Function
REQ-010 The FSM SHALL have states IDLE, DIV_BUSY, EXC_DRAIN, and all stall/flush outputs SHALL be combinational from the state and current inputs.
REQ-011 Event priority SHALL be: except_valid > dmem_busy > divide > load-use; only the highest active event drives outputs.
REQ-012 On except_valid (any state), the block SHALL assert flush_d, flush_e, flush_m, flush_w and redirect, with all stalls 0, and go to EXC_DRAIN.
REQ-013 If except_valid occurs in DIV_BUSY, the block SHALL also pulse div_cancel for that cycle.
REQ-014 In EXC_DRAIN, the block SHALL assert flush_d only (kills the wrong-path fetch already in SRAM flight), redirect 0, and return to IDLE next cycle unless except_valid re-asserts.
REQ-015 On dmem_busy (no exception), the block SHALL assert stall_f, stall_d, stall_e, stall_m and flush_w (WB bubble); the state holds.
REQ-016 In IDLE with div_start, the block SHALL assert stall_f, stall_d, stall_e and flush_m, and go to DIV_BUSY.
REQ-017 In DIV_BUSY with div_done=0, the block SHALL drive the same outputs as REQ-016.
REQ-018 In DIV_BUSY with div_done=1, all stalls SHALL be 0 (EX advances with the result) and the state SHALL go to IDLE; div_start is ignored in DIV_BUSY.
REQ-019 If dmem_busy occurs in DIV_BUSY, the state SHALL remain DIV_BUSY, and a div_done seen in that cycle SHALL be ignored; the divider holds its result until the block acknowledges it.
REQ-020 Load-use is true when ex_memtoreg & ex_regwrite & ex_writereg!=0 & ((id_use_rs & id_rs==ex_writereg) | (id_use_rt & id_rt==ex_writereg)).
REQ-021 On load-use in IDLE (no higher event), the block SHALL assert stall_f, stall_d and flush_e for exactly that cycle.
REQ-022 stall_cnt SHALL increment by 1 on each cycle with stall_f=1, wrapping 0xFFFFFFFF->0.
REQ-023 When no event is active, all stall, flush, redirect and div_cancel outputs SHALL be 0.

Reset
REQ-024 While resetn=0 at the clock edge, the state SHALL become IDLE and stall_cnt 0.
REQ-025 While resetn=0, all stall, flush, redirect and div_cancel outputs SHALL be forced to 0.
REQ-026 A reset during DIV_BUSY or EXC_DRAIN SHALL abandon the operation, with no div_cancel pulse.

Verification
REQ-027 The bench SHALL check load-use: ex_memtoreg=1, ex_regwrite=1, ex_writereg=8, id_rs=8, id_use_rs=1 -> stall_f=stall_d=flush_e=1 for 1 cycle, and stall_cnt 0->1.
REQ-028 The bench SHALL check ex_writereg=0 with the same match as REQ-027 -> no stall.
REQ-029 The bench SHALL check divide: div_start at cycle 0 with div_done at cycle 5 -> stall_f/d/e and flush_m high cycles 0-4, all stalls 0 at cycle 5, IDLE at cycle 6, and stall_cnt=5.
REQ-030 The bench SHALL check except_valid at cycle 3 of DIV_BUSY -> flush_d/e/m/w=1, redirect=1, div_cancel=1, then flush_d only next cycle, then IDLE.
REQ-031 The bench SHALL check dmem_busy for 3 cycles together with load-use -> stall_f/d/e/m and flush_w for 3 cycles, then the load-use stall for 1 cycle.
REQ-032 The bench SHALL check stall_cnt preset near wrap (0xFFFFFFFE) with 2 stall cycles -> 0x00000000, and resetn=0 mid-DIV_BUSY -> outputs 0, state IDLE, stall_cnt 0.
